// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared immediate-extension mode encoding
package imm_pkg;

  typedef enum logic [1:0] {
    MODE_SEXT   = 2'b00,
    MODE_ZEXT   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } ext_mode_t;

endpackage

// File: rtl/imm_ext_comb.sv
// rtl/imm_ext_comb.sv - combinational IN_W to OUT_W immediate extender
module imm_ext_comb
  import imm_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] result
);

  logic [OUT_W-1:0] sext;

  always_comb begin
    sext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    result = '0;
    case (mode)
      MODE_SEXT:   result = sext;
      MODE_ZEXT:   result = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_UPPER:  result = {imm, {(OUT_W-IN_W){1'b0}}};
      // Branch offsets are word-scaled; the top two sign copies fall off.
      MODE_BRANCH: result = {sext[OUT_W-3:0], 2'b00};
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/imm_extender.sv
// rtl/imm_extender.sv - immediate extender feeding a DEPTH-entry result FIFO
module imm_extender
  import imm_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_imm,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [OUT_W-1:0] ext_result;
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  imm_ext_comb #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .imm    (in_imm),
    .mode   (ext_mode_t'(in_mode)),
    .result (ext_result)
  );

  // Non-power-of-two depths need an explicit wrap rather than natural overflow.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; out_data is masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ext_result;
  end

endmodule

// File: tb/tb_imm_extender.sv
// tb/tb_imm_extender.sv - self-checking bench for imm_extender over three parameter sets
module tb_imm_extender;

  logic clk;
  logic rst_n;

  logic        i0_valid, r0_ready, o0_valid, i0_ready;
  logic [15:0] i0_imm;
  logic [1:0]  i0_mode;
  logic [31:0] o0_data;
  logic [1:0]  o0_count;

  logic        i1_valid, r1_ready, o1_valid, i1_ready;
  logic [15:0] i1_imm;
  logic [1:0]  i1_mode;
  logic [31:0] o1_data;
  logic [1:0]  o1_count;

  logic        i2_valid, r2_ready, o2_valid, i2_ready;
  logic [11:0] i2_imm;
  logic [1:0]  i2_mode;
  logic [19:0] o2_data;
  logic [2:0]  o2_count;

  int n_vec  = 0;
  int n_fail = 0;

  longint q0[$];
  longint q1[$];
  longint q2[$];

  imm_extender u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(i0_valid), .in_ready(i0_ready),
    .in_imm(i0_imm), .in_mode(i0_mode), .out_valid(o0_valid),
    .out_ready(r0_ready), .out_data(o0_data), .count(o0_count)
  );

  imm_extender #(.IN_W(16), .OUT_W(32), .DEPTH(3)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(i1_valid), .in_ready(i1_ready),
    .in_imm(i1_imm), .in_mode(i1_mode), .out_valid(o1_valid),
    .out_ready(r1_ready), .out_data(o1_data), .count(o1_count)
  );

  imm_extender #(.IN_W(12), .OUT_W(20), .DEPTH(5)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(i2_valid), .in_ready(i2_ready),
    .in_imm(i2_imm), .in_mode(i2_mode), .out_valid(o2_valid),
    .out_ready(r2_ready), .out_data(o2_data), .count(o2_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint ext_model(input longint imm, input int mode,
                                       input int in_w, input int out_w);
    longint v;
    longint full;
    full = longint'(1) << in_w;
    v = imm & (full - 1);
    if ((mode == 0 || mode == 3) && v >= full / 2) v = v - full;
    if (mode == 2) v = v * (longint'(1) << (out_w - in_w));
    if (mode == 3) v = v * 4;
    return v & ((longint'(1) << out_w) - 1);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
    q2.delete();
  end

  always @(posedge clk) begin : model
    bit p0, p1, p2, d0, d1, d2;
    if (rst_n) begin
      d0 = q0.size() != 0 && r0_ready;
      d1 = q1.size() != 0 && r1_ready;
      d2 = q2.size() != 0 && r2_ready;
      p0 = i0_valid && q0.size() != 2;
      p1 = i1_valid && q1.size() != 3;
      p2 = i2_valid && q2.size() != 5;
      if (d0) void'(q0.pop_front());
      if (d1) void'(q1.pop_front());
      if (d2) void'(q2.pop_front());
      if (p0) q0.push_back(ext_model(longint'(i0_imm), int'(i0_mode), 16, 32));
      if (p1) q1.push_back(ext_model(longint'(i1_imm), int'(i1_mode), 16, 32));
      if (p2) q2.push_back(ext_model(longint'(i2_imm), int'(i2_mode), 12, 20));
    end
  end

  always @(negedge clk) begin : compare
    check("u0.out_valid", longint'(o0_valid), longint'(q0.size() != 0));
    check("u0.in_ready",  longint'(i0_ready), longint'(q0.size() != 2));
    check("u0.count",     longint'(o0_count), longint'(q0.size()));
    check("u0.out_data",  longint'(o0_data),  q0.size() != 0 ? q0[0] : 0);
    check("u1.out_valid", longint'(o1_valid), longint'(q1.size() != 0));
    check("u1.in_ready",  longint'(i1_ready), longint'(q1.size() != 3));
    check("u1.count",     longint'(o1_count), longint'(q1.size()));
    check("u1.out_data",  longint'(o1_data),  q1.size() != 0 ? q1[0] : 0);
    check("u2.out_valid", longint'(o2_valid), longint'(q2.size() != 0));
    check("u2.in_ready",  longint'(i2_ready), longint'(q2.size() != 5));
    check("u2.count",     longint'(o2_count), longint'(q2.size()));
    check("u2.out_data",  longint'(o2_data),  q2.size() != 0 ? q2[0] : 0);
  end

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t sweep[6];

  initial begin
    sweep[0] = '{16'h20DD, 2'b00, 32'h000020DD};
    sweep[1] = '{16'h8001, 2'b00, 32'hFFFF8001};
    sweep[2] = '{16'h8001, 2'b01, 32'h00008001};
    sweep[3] = '{16'h1234, 2'b10, 32'h12340000};
    sweep[4] = '{16'hFFFF, 2'b11, 32'hFFFFFFFC};
    sweep[5] = '{16'h0004, 2'b11, 32'h00000010};

    rst_n = 1'b0;
    {i0_valid, r0_ready, i0_imm, i0_mode} = '0;
    {i1_valid, r1_ready, i1_imm, i1_mode} = '0;
    {i2_valid, r2_ready, i2_imm, i2_mode} = '0;
    #2;
    check("reset.out_valid", longint'(o0_valid), 0);
    check("reset.in_ready",  longint'(i0_ready), 1);
    check("reset.count",     longint'(o0_count), 0);
    check("reset.out_data",  longint'(o0_data),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Empty: consumer ready, nothing pushed
    r0_ready = 1'b1;
    step();
    step();
    check("empty.out_valid", longint'(o0_valid), 0);
    check("empty.out_data",  longint'(o0_data),  0);

    // Mode sweep, each result one cycle after its push and not before
    i0_valid = 1'b1;
    i0_imm   = sweep[0].imm;
    i0_mode  = sweep[0].mode;
    #1;
    check("sweep.no_bypass", longint'(o0_valid), 0);
    for (int i = 0; i < 6; i++) begin
      i0_imm  = sweep[i].imm;
      i0_mode = sweep[i].mode;
      step();
      check($sformatf("sweep[%0d]", i), longint'(o0_data), longint'(sweep[i].exp));
      check($sformatf("sweep[%0d].valid", i), longint'(o0_valid), 1);
    end
    i0_valid = 1'b0;
    step();
    check("sweep.drained", longint'(o0_count), 0);

    // Fill DEPTH=2 with consumer stalled; third value must bounce
    r0_ready = 1'b0;
    i0_valid = 1'b1;
    i0_mode  = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      i0_imm = 16'(i);
      step();
    end
    i0_valid = 1'b0;
    check("fill.count",    longint'(o0_count), 2);
    check("fill.in_ready", longint'(i0_ready), 0);
    r0_ready = 1'b1;
    check("fill.head0", longint'(o0_data), 32'h1);
    step();
    check("fill.head1", longint'(o0_data), 32'h2);
    step();
    check("fill.empty", longint'(o0_count), 0);

    // DEPTH=3 streaming at count=1 across several pointer wraps
    i1_valid = 1'b1;
    i1_mode  = 2'b01;
    i1_imm   = 16'd100;
    step();
    r1_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      i1_imm = 16'(100 + i);
      check("stream.head", longint'(o1_data), longint'(100 + i - 1));
      step();
      check("stream.count", longint'(o1_count), 1);
    end
    i1_valid = 1'b0;
    check("stream.last", longint'(o1_data), 110);
    step();
    check("stream.empty", longint'(o1_count), 0);

    // Parameter variant IN_W=12 OUT_W=20 DEPTH=5
    i2_valid = 1'b1;
    i2_imm = 12'h800; i2_mode = 2'b00; step();
    i2_imm = 12'hABC; i2_mode = 2'b10; step();
    i2_imm = 12'hFFF; i2_mode = 2'b11; step();
    i2_imm = 12'h7FF; i2_mode = 2'b00; step();
    i2_imm = 12'h001; i2_mode = 2'b01; step();
    i2_imm = 12'h123; step();
    i2_valid = 1'b0;
    check("var.count",    longint'(o2_count), 5);
    check("var.in_ready", longint'(i2_ready), 0);
    r2_ready = 1'b1;
    check("var.sext", longint'(o2_data), 20'hFF800);
    step();
    check("var.upper", longint'(o2_data), 20'hABC00);
    step();
    check("var.branch", longint'(o2_data), 20'hFFFFC);
    for (int i = 0; i < 3; i++) step();
    check("var.empty", longint'(o2_count), 0);

    // Reset mid-operation, asserted between clock edges
    r0_ready = 1'b0;
    i0_valid = 1'b1;
    i0_mode  = 2'b01;
    i0_imm   = 16'h5555; step();
    i0_imm   = 16'h6666; step();
    check("rst.pre_count", longint'(o0_count), 2);
    i0_imm  = 16'hFFFF;
    i0_mode = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.out_valid", longint'(o0_valid), 0);
    check("rst.in_ready",  longint'(i0_ready), 1);
    check("rst.count",     longint'(o0_count), 0);
    check("rst.out_data",  longint'(o0_data),  0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();
    i0_valid = 1'b0;
    check("rst.first_push", longint'(o0_data), 32'hFFFFFFFF);
    check("rst.one_entry",  longint'(o0_count), 1);
    r0_ready = 1'b1;
    step();
    check("rst.no_stale", longint'(o0_valid), 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
